csa_accum_ctrl: RTL
===================

Name: csa_accum_ctrl

Overview:
- Sequencing controller for a shared carry-save adder (CSA) datapath in the float MAC.
- Accepts a burst of LEN operands over a valid/ready stream.
- Accumulates operands in carry-save form: one 3:2 compression per accepted operand, no carry propagation per operand.
- Resolves the final sum with a single carry-propagate add, then presents the result on a valid/ready output.

Parameters:
- BW, 8, operand width in bits.
- NMAX_W, 4, width of the burst-length field; max burst is 2^NMAX_W-1 operands.
- Derived (not a parameter): AW = BW+NMAX_W, accumulator and result width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a burst; sampled only in IDLE.
- len  input  NMAX_W  operand count for the burst; sampled with start.
- in_valid  input  1  operand valid.
- in_ready  output  1  controller accepts an operand this cycle.
- in_data  input  BW  operand.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  AW  resolved sum.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE; S, C, count and out_sum cleared to 0.
  - in_ready=0, out_valid=0, busy=0.
  - Applies from any state; an in-flight burst is discarded with no partial result.
- Internal registers:
  - S[AW-1:0]: sum vector.
  - C[AW-1:0]: carry vector, stored pre-shifted (bit 0 always 0).
  - count[NMAX_W-1:0]: operands remaining.
- IDLE:
  - start=1 with len!=0: S=0, C=0, count=len, go to ACCUM.
  - start=1 with len=0: S=0, C=0, go directly to RESOLVE; the result is 0.
- ACCUM:
  - in_ready=1.
  - On in_valid&in_ready, with X = in_data extended to AW:
    - S <= S^C^X.
    - C <= ((S&C)|(S&X)|(C&X)) << 1, truncated to AW.
    - count <= count-1.
  - When the handshake consumes the last operand (count==1), go to RESOLVE.
  - in_valid gaps are allowed; state and registers hold.
- RESOLVE: exactly 1 cycle; in_ready=0; out_sum <= S+C (AW-bit add, carry-out discarded); go to DONE.
- DONE:
  - out_valid=1; out_sum is held stable until out_valid&out_ready.
  - On that handshake, go to IDLE; out_valid drops the next cycle.
- Latency: the last operand handshake at edge k is followed by out_valid=1 from edge k+2.
  - len=0: start at edge k is followed by out_valid from edge k+2.
- Width: the sum of at most 2^NMAX_W-1 BW-bit operands fits AW bits in both unsigned and signed modes, so overflow is impossible.
- Simultaneous and boundary events:
  - start outside IDLE is ignored, including in the DONE cycle where the output handshake completes. A new burst needs start in IDLE, one cycle later at the earliest.
  - in_valid outside ACCUM is ignored; in_ready=0 there.
  - out_ready outside DONE has no effect.
  - rst together with any handshake: reset wins.
- Back-to-back throughput: one operand per cycle in ACCUM. Per-burst overhead is 1 IDLE cycle, 1 RESOLVE cycle and at least 1 DONE cycle.

Optional Feature:
- Macro: CSA_ACCUM_CTRL_SIGNED_EN.
- Defined: in_data is two's complement, sign-extended to AW; out_sum is a two's-complement AW-bit result.
- Undefined: in_data is unsigned, zero-extended to AW; out_sum is unsigned.
- All other timing and handshake behaviour is identical in both builds.

Test Plan (BW=8, NMAX_W=4, AW=12):
- Unsigned build: start, len=3, operands 0xFF,0xFF,0xFF with in_valid continuous, out_ready=1 -> out_valid 2 cycles after the 3rd handshake, out_sum=0x2FD; busy low again after the output handshake.
- start with len=0 -> no in_ready assertion; out_valid 2 cycles later with out_sum=0x000.
- len=15, all operands 0xFF, in_valid toggled 1/0 every cycle -> exactly 15 handshakes; out_sum=0xEF1.
- Backpressure: len=2, operands 0x12,0x34, out_ready held 0 for 5 cycles -> out_valid and out_sum=0x046 stable for all 5 cycles, then clear 1 cycle after out_ready=1.
- Interference and reset: start pulsed during ACCUM of len=4 (operands 1,2,3,4) -> ignored, out_sum=0x00A. Repeat with rst=1 after the 2nd operand -> IDLE next cycle with all outputs 0; a new burst of len=1, operand 0x07 -> out_sum=0x007.
- Signed build (CSA_ACCUM_CTRL_SIGNED_EN defined): len=2, operands 0x80,0x80 -> out_sum=0xF00 (-256). Operands 0x7F,0x81 -> out_sum=0x000.

Source files
------------

// File: rtl/csa_accum_ctrl.sv
// Burst accumulator controller for a shared carry-save adder: one 3:2 compression per operand,
// one carry-propagate add at the end. Define CSA_ACCUM_CTRL_SIGNED_EN for two's-complement operands.
module csa_accum_ctrl #(
    parameter int BW     = 8,
    parameter int NMAX_W = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [NMAX_W-1:0]    i_len,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [BW-1:0]        i_in_data,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [BW+NMAX_W-1:0] o_out_sum,
    output logic                 o_busy
);

    localparam int AW = BW + NMAX_W;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StResolve,
        StDone
    } state_t;

    state_t            r_state;
    logic [AW-1:0]     r_sum;
    logic [AW-1:0]     r_carry;
    logic [AW-1:0]     r_out_sum;
    logic [NMAX_W-1:0] r_count;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_busy;

    logic [AW-1:0]     w_x;
    logic [AW-1:0]     w_sum_nxt;
    logic [AW-1:0]     w_maj;
    logic [AW-1:0]     w_carry_nxt;
    logic [AW-1:0]     w_resolved;
    logic              w_in_hs;
    logic              w_out_hs;

`ifdef CSA_ACCUM_CTRL_SIGNED_EN
    assign w_x = {{NMAX_W{i_in_data[BW-1]}}, i_in_data};
`else
    assign w_x = {{NMAX_W{1'b0}}, i_in_data};
`endif

    assign w_sum_nxt   = r_sum ^ r_carry ^ w_x;
    assign w_maj       = (r_sum & r_carry) | (r_sum & w_x) | (r_carry & w_x);
    // Carry is kept pre-shifted so the final resolve is a plain S+C.
    assign w_carry_nxt = w_maj << 1;
    assign w_resolved  = r_sum + r_carry;

    // r_in_ready is high exactly while in StAccum.
    assign w_in_hs  = r_in_ready & i_in_valid;
    assign w_out_hs = r_out_valid & i_out_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_sum       <= '0;
            r_carry     <= '0;
            r_count     <= '0;
            r_out_sum   <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_sum   <= '0;
                        r_carry <= '0;
                        r_count <= i_len;
                        r_busy  <= 1'b1;
                        if (i_len != '0) begin
                            r_state    <= StAccum;
                            r_in_ready <= 1'b1;
                        end else begin
                            r_state <= StResolve;
                        end
                    end
                end
                StAccum: begin
                    if (w_in_hs) begin
                        r_sum   <= w_sum_nxt;
                        r_carry <= w_carry_nxt;
                        r_count <= r_count - NMAX_W'(1);
                        if (r_count == NMAX_W'(1)) begin
                            r_state    <= StResolve;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                StResolve: begin
                    r_out_sum   <= w_resolved;
                    r_out_valid <= 1'b1;
                    r_state     <= StDone;
                end
                StDone: begin
                    if (w_out_hs) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                default: begin
                    r_state     <= StIdle;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_sum   = r_out_sum;
    assign o_busy      = r_busy;

endmodule
